// File: rtl/controle_exibe_sequencia.sv
// Playback sequencer: walks the address counter from 0 to the limit, lighting the LEDs
// for T_ON cycles and darkening them for T_OFF cycles per address.
// Optional pause input enabled by defining CONTROLE_EXIBE_PAUSA_EN.
module controle_exibe_sequencia #(
    parameter int unsigned T_ON    = 1000,
    parameter int unsigned T_OFF   = 500,
    parameter int unsigned TIMER_W = 11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       abortar,
`ifdef CONTROLE_EXIBE_PAUSA_EN
    input  logic       pausa,
`endif
    input  logic       enderecoIgualLimite,
    output logic       zeraE,
    output logic       contaE,
    output logic       leds_ativos,
    output logic       ocupado,
    output logic       fim,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        StOcioso        = 4'd0,
        StPrepara       = 4'd1,
        StAcende        = 4'd2,
        StApaga         = 4'd3,
        StProximo       = 4'd4,
        StFinalExibicao = 4'd5
    } estado_e;

    localparam logic [TIMER_W-1:0] TonLast  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] ToffLast = TIMER_W'(T_OFF - 1);

    estado_e              r_estado;
    estado_e              w_estado_d;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_d;
    logic                 w_pausa;

`ifdef CONTROLE_EXIBE_PAUSA_EN
    assign w_pausa = pausa;
`else
    assign w_pausa = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= StOcioso;
            r_timer  <= '0;
        end else begin
            r_estado <= w_estado_d;
            r_timer  <= w_timer_d;
        end
    end

    // Next state and timer; the timer is cleared everywhere except while counting.
    always_comb begin
        w_estado_d = r_estado;
        w_timer_d  = '0;
        case (r_estado)
            StOcioso: begin
                if (iniciar) w_estado_d = StPrepara;
            end
            StPrepara: begin
                w_estado_d = StAcende;
            end
            StAcende: begin
                if (w_pausa) begin
                    w_timer_d = r_timer;
                end else if (r_timer == TonLast) begin
                    w_estado_d = StApaga;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StApaga: begin
                if (w_pausa) begin
                    w_timer_d = r_timer;
                end else if (r_timer == ToffLast) begin
                    w_estado_d = enderecoIgualLimite ? StFinalExibicao : StProximo;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StProximo: begin
                w_estado_d = StAcende;
            end
            StFinalExibicao: begin
                w_estado_d = StOcioso;
            end
            default: begin
                w_estado_d = StOcioso;
            end
        endcase

        // Cancel wins over everything, pause included; it is inert when already idle.
        if (abortar && (r_estado != StOcioso)) begin
            w_estado_d = StOcioso;
            w_timer_d  = '0;
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        zeraE       = 1'b0;
        contaE      = 1'b0;
        leds_ativos = 1'b0;
        ocupado     = 1'b0;
        fim         = 1'b0;
        db_estado   = 4'hF;
        case (r_estado)
            StOcioso: begin
                db_estado = 4'd0;
            end
            StPrepara: begin
                zeraE     = 1'b1;
                ocupado   = 1'b1;
                db_estado = 4'd1;
            end
            StAcende: begin
                leds_ativos = 1'b1;
                ocupado     = 1'b1;
                db_estado   = 4'd2;
            end
            StApaga: begin
                ocupado   = 1'b1;
                db_estado = 4'd3;
            end
            StProximo: begin
                contaE    = 1'b1;
                ocupado   = 1'b1;
                db_estado = 4'd4;
            end
            StFinalExibicao: begin
                fim       = 1'b1;
                ocupado   = 1'b1;
                db_estado = 4'd5;
            end
            default: begin
                db_estado = 4'hF;
            end
        endcase
    end

endmodule

// File: tb/tb_controle_exibe_sequencia.sv
// Self-checking bench for controle_exibe_sequencia with T_ON=4, T_OFF=2.
// Expected outputs come from a cycle-schedule model built from the playback timing rules.
module tb_controle_exibe_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       abortar = 1'b0;
    logic       pausa = 1'b0;
    logic       enderecoIgualLimite;
    logic       zeraE, contaE, leds_ativos, ocupado, fim;
    logic [3:0] db_estado;

    int n_err = 0;
    int n_chk = 0;
    int tb_lim = 0;
    int tb_cnt = 0;
    bit tie_eil = 1'b0;

    controle_exibe_sequencia #(
        .T_ON(T_ON),
        .T_OFF(T_OFF),
        .TIMER_W(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .abortar(abortar),
`ifdef CONTROLE_EXIBE_PAUSA_EN
        .pausa(pausa),
`endif
        .enderecoIgualLimite(enderecoIgualLimite),
        .zeraE(zeraE),
        .contaE(contaE),
        .leds_ativos(leds_ativos),
        .ocupado(ocupado),
        .fim(fim),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Datapath model: address counter compared against the current limit.
    always @(posedge clock) begin
        if (zeraE) tb_cnt <= 0;
        else if (contaE) tb_cnt <= tb_cnt + 1;
    end
    assign enderecoIgualLimite = tie_eil | (tb_cnt == tb_lim);

    // {zeraE, contaE, leds, ocupado, fim, db[3:0]} for cycle c after iniciar is sampled.
    function automatic logic [8:0] model(int c, int lim);
        int per, off, k, r, fimc;
        per  = T_ON + T_OFF + 1;
        fimc = 2 + (lim + 1) * (T_ON + T_OFF) + lim;
        if (c == 1) return {5'b10010, 4'd1};
        if (c == fimc) return {5'b00011, 4'd5};
        if (c < 2 || c > fimc) return 9'd0;
        off = c - 2;
        k   = off / per;
        r   = off % per;
        if (k > lim) return 9'd0;
        if (r < T_ON) return {5'b00110, 4'd2};
        if (r < T_ON + T_OFF) return {5'b00010, 4'd3};
        return {5'b01010, 4'd4};
    endfunction

    function automatic logic [8:0] obs();
        return {zeraE, contaE, leds_ativos, ocupado, fim, db_estado};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_chk++;
        if (obs() !== 9'd0) begin
            n_err++;
            $display("FAIL reset: got %b expected %b", obs(), 9'd0);
        end
        tick();
        reset = 1'b1;
        tick();
        n_chk++;
        if (obs() !== 9'd0) begin
            n_err++;
            $display("FAIL reset_release: got %b expected %b", obs(), 9'd0);
        end
    endtask

    task automatic test_playback(int lim, bit hold, bit both);
        int fimc, n_conta;
        fimc    = 2 + (lim + 1) * (T_ON + T_OFF) + lim;
        n_conta = 0;
        tb_lim  = lim;
        iniciar = 1'b1;
        abortar = both;
        for (int c = 1; c <= fimc + 1; c++) begin
            tick();
            if (!hold) iniciar = 1'b0;
            abortar = 1'b0;
            if (contaE === 1'b1) n_conta++;
            n_chk++;
            if (obs() !== model(c, lim)) begin
                n_err++;
                $display("FAIL play L=%0d cycle %0d: got %b expected %b",
                         lim, c, obs(), model(c, lim));
            end
        end
        n_chk++;
        if (n_conta != lim) begin
            n_err++;
            $display("FAIL conta_pulses L=%0d: got %0d expected %0d", lim, n_conta, lim);
        end
        if (hold) begin
            tick();
            iniciar = 1'b0;
            n_chk++;
            if (obs() !== {5'b10010, 4'd1}) begin
                n_err++;
                $display("FAIL hold_restart: got %b expected %b", obs(), {5'b10010, 4'd1});
            end
            abortar = 1'b1;
            tick();
            abortar = 1'b0;
            n_chk++;
            if (obs() !== 9'd0) begin
                n_err++;
                $display("FAIL hold_abort: got %b expected %b", obs(), 9'd0);
            end
        end
    endtask

    task automatic test_abort();
        tb_lim  = 2;
        iniciar = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            iniciar = 1'b0;
        end
        n_chk++;
        if (obs() !== {5'b00110, 4'd2}) begin
            n_err++;
            $display("FAIL abort_pre: got %b expected %b", obs(), {5'b00110, 4'd2});
        end
        abortar = 1'b1;
        tick();
        abortar = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_chk++;
            if (obs() !== 9'd0) begin
                n_err++;
                $display("FAIL abort_idle %0d: got %b expected %b", c, obs(), 9'd0);
            end
            tick();
        end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_chk++;
        if (obs() !== {5'b10010, 4'd1}) begin
            n_err++;
            $display("FAIL abort_restart: got %b expected %b", obs(), {5'b10010, 4'd1});
        end
        abortar = 1'b1;
        tick();
        abortar = 1'b0;
    endtask

    task automatic test_async_reset();
        tb_lim  = 0;
        iniciar = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            iniciar = 1'b0;
        end
        n_chk++;
        if (obs() !== {5'b00010, 4'd3}) begin
            n_err++;
            $display("FAIL areset_pre: got %b expected %b", obs(), {5'b00010, 4'd3});
        end
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (obs() !== 9'd0) begin
            n_err++;
            $display("FAIL areset_immediate: got %b expected %b", obs(), 9'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if (obs() !== 9'd0) begin
                n_err++;
                $display("FAIL areset_stay %0d: got %b expected %b", c, obs(), 9'd0);
            end
        end
    endtask

`ifdef CONTROLE_EXIBE_PAUSA_EN
    task automatic test_pausa();
        int n_leds, fimc;
        n_leds  = 0;
        fimc    = -1;
        tb_lim  = 0;
        iniciar = 1'b1;
        for (int c = 1; c <= 40 && fimc < 0; c++) begin
            tick();
            iniciar = 1'b0;
            if (c == 3) pausa = 1'b1;
            if (c == 13) pausa = 1'b0;
            if (leds_ativos === 1'b1) n_leds++;
            if (fim === 1'b1) fimc = c;
        end
        pausa = 1'b0;
        n_chk++;
        if (n_leds != 14) begin
            n_err++;
            $display("FAIL pausa_leds: got %0d expected %0d", n_leds, 14);
        end
        n_chk++;
        if (fimc != 18) begin
            n_err++;
            $display("FAIL pausa_fim: got %0d expected %0d", fimc, 18);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        tie_eil = 1'b1;
        test_playback(0, 1'b0, 1'b0);
        tie_eil = 1'b0;
        test_playback(2, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            test_playback(int'($urandom_range(0, 4)), 1'b0, 1'($urandom_range(0, 1)));
        end
        test_abort();
        test_async_reset();
        test_playback(1, 1'b1, 1'b0);
`ifdef CONTROLE_EXIBE_PAUSA_EN
        test_pausa();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/controle_exibe_sequencia.md
Name: controle_exibe_sequencia

Overview:
- Sequencer that plays the stored sequence on the LEDs before the player's turn.
- Walks the address counter from 0 to the current limit: LEDs on for T_ON cycles, then off for T_OFF cycles, per address.
- Sits between the game control unit, which starts it and waits for fim, and the shared datapath (address counter, memory, LED driver).
- Owns an internal cycle timer.

Parameters:
- T_ON, 1000, cycles LEDs stay lit per element (≥1)
- T_OFF, 500, cycles LEDs stay dark after each element (≥1)
- TIMER_W, 11, internal timer width; must satisfy 2^TIMER_W > max(T_ON, T_OFF)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0) reset
- iniciar  in  1  start request; sampled only in ocioso
- abortar  in  1  cancel playback; returns to ocioso
- enderecoIgualLimite  in  1  datapath: address counter equals current limit
- zeraE  out  1  clear address counter
- contaE  out  1  increment address counter
- leds_ativos  out  1  enable LED driver to show memory data
- ocupado  out  1  high in every state except ocioso
- fim  out  1  one-cycle pulse: playback complete
- db_estado  out  4  debug state code

Behaviour:
- Moore FSM; all outputs decode from the registered state only.
- Reset asserted (reset=0): state=ocioso, timer=0, all outputs 0, db_estado=0. Takes effect immediately, mid-playback included.
- States (db_estado): ocioso(0), prepara(1), acende(2), apaga(3), proximo(4), final_exibicao(5). Any unused code -> db_estado=F, next state ocioso.
- ocioso: all outputs 0. iniciar=1 -> prepara.
- prepara (1 cycle): zeraE=1, ocupado=1, timer cleared -> acende.
- acende: leds_ativos=1, ocupado=1. Timer increments each cycle. At timer==T_ON-1 -> apaga, timer cleared. acende lasts exactly T_ON cycles.
- apaga: leds_ativos=0, ocupado=1. Timer increments. At timer==T_OFF-1, timer cleared, then:
  - enderecoIgualLimite=1 -> final_exibicao
  - otherwise -> proximo
- proximo (1 cycle): contaE=1 -> acende.
- final_exibicao (1 cycle): fim=1, ocupado=1 -> ocioso.
- enderecoIgualLimite is evaluated only on the last apaga cycle. The datapath guarantees it is stable one cycle after contaE.
- abortar=1 in any state other than ocioso: next state ocioso, timer cleared, no fim. abortar has priority over all other transitions. abortar in ocioso has no effect.
- iniciar while ocupado=1: ignored. iniciar and abortar both high in ocioso: go to prepara (abortar has no effect in ocioso).
- At most one of zeraE/contaE is high in any cycle.
- Timer wraps are impossible by construction: it is always cleared on reaching its terminal count.
- Latency for limit L (addresses 0..L), counted from the clock edge that samples iniciar to the fim cycle: 1 + (L+1)·(T_ON+T_OFF) + L + 1 cycles.
- contaE pulses exactly L times per playback.

Optional Feature:
- Macro: CONTROLE_EXIBE_PAUSA_EN.
- Defined: extra input pausa (1 bit). While pausa=1 in acende or apaga, the timer holds and the state holds; leds_ativos keeps its current value. pausa has no effect in other states. abortar still overrides pausa.
- Undefined: no pausa port; timer always advances in acende/apaga.

Test Plan:
- T_ON=4, T_OFF=2, L=0 (enderecoIgualLimite tied 1): pulse iniciar -> zeraE in cycle 1; leds_ativos high cycles 2-5; fim in cycle 8; contaE never high.
- T_ON=4, T_OFF=2, L=2 (datapath model with counter): fim in cycle 22; contaE exactly 2 pulses; leds_ativos exactly 3 high windows of 4 cycles; db_estado sequence 1,2,3,4,2,3,4,2,3,5,0.
- abortar=1 during second acende -> ocioso next cycle; ocupado=0, leds_ativos=0, no fim; a new iniciar restarts from prepara with zeraE.
- reset=0 asserted asynchronously mid-apaga -> all outputs 0 immediately, without waiting for a clock edge; after release, stays ocioso until iniciar.
- iniciar held high continuously through playback -> only one playback; after fim, a new playback starts from prepara on the next iniciar sample.
- CONTROLE_EXIBE_PAUSA_EN defined, pausa=1 for 10 cycles inside acende -> acende window lengthens to 14 cycles; fim is delayed by exactly 10 cycles.
